// File: rtl/regfile_pkg.sv
// Shared defaults and the port-slice helper used to index the packed
// rd_addr/rd_data buses.
package regfile_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  // Low bit of port `port` in a bus packed as NUM_RD slices of width `w`.
  function automatic int unsigned port_lo(int unsigned port, int unsigned w);
    return port * w;
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits plus an incrementally maintained pending count.
// When an issue and a writeback hit the same register, the issue wins.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_en_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  input  logic                     iss_en_i,
  input  logic [ADDR_W-1:0]        iss_addr_i,
  output logic [(1<<ADDR_W)-1:0]   pend_o,
  output logic [ADDR_W:0]          pend_cnt_o
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] pend_q, pend_d;
  logic [ADDR_W:0]  cnt_q, cnt_d;
  logic             iss_ok, wr_ok, inc, dec;

  assign iss_ok = iss_en_i && !((ZERO_REG != 0) && (iss_addr_i == '0));
  assign wr_ok  = wr_en_i  && !((ZERO_REG != 0) && (wr_addr_i  == '0));
  // A clear on the register being re-issued in the same cycle is void.
  assign inc = iss_ok && !pend_q[iss_addr_i];
  assign dec = wr_ok && pend_q[wr_addr_i] && !(iss_ok && (iss_addr_i == wr_addr_i));

  always_comb begin
    pend_d = pend_q;
    if (wr_ok)  pend_d[wr_addr_i]  = 1'b0;
    if (iss_ok) pend_d[iss_addr_i] = 1'b1;
    cnt_d = cnt_q;
    if (inc && !dec)      cnt_d = cnt_q + (ADDR_W+1)'(1);
    else if (dec && !inc) cnt_d = cnt_q - (ADDR_W+1)'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend_o     = pend_q;
  assign pend_cnt_o = cnt_q;
endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with optional write bypass, hardwired zero
// register and a pending scoreboard for decode hazard detection.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [ADDR_W:0]          pend_cnt
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic              wr_ok;

  assign wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < DEPTH; r++) mem_q[r] <= '0;
    end else if (wr_ok) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  regfile_scoreboard #(.ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_sb (
    .clk_i      (clk),
    .rst_ni     (reset),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .iss_en_i   (iss_en),
    .iss_addr_i (iss_addr),
    .pend_o     (pend),
    .pend_cnt_o (pend_cnt)
  );

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              byp, zr;

    assign a   = rd_addr[port_lo(i, ADDR_W) +: ADDR_W];
    // Forwarding is gated by reset so the outputs stay quiet while held.
    assign byp = (BYPASS != 0) && reset && wr_ok && (wr_addr == a);
    assign zr  = (ZERO_REG != 0) && (a == '0);
    assign rd_data[port_lo(i, DATA_W) +: DATA_W] =
      !reset ? '0 : byp ? wr_data : zr ? '0 : mem_q[a];
    assign rd_busy[i] = reset && !byp && pend[a];
  end
endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data_b, rd_data_n;
  logic [NR-1:0]    rd_busy_b, rd_busy_n;
  logic             wr_en, iss_en;
  logic [AW-1:0]    wr_addr, iss_addr;
  logic [DW-1:0]    wr_data;
  logic [AW:0]      pend_cnt_b, pend_cnt_n;
  logic             done = 1'b0;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)) u_byp (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
    .iss_addr(iss_addr), .pend_cnt(pend_cnt_b));

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(0)) u_nob (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
    .iss_addr(iss_addr), .pend_cnt(pend_cnt_n));

  typedef struct {
    string       name;
    int          kind;
    int          dut;
    int          port;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic ex(input string nm, input int kind, input int dut, input int port,
                    input logic [31:0] v);
    exp_t e;
    e.name = nm; e.kind = kind; e.port = port; e.exp = v;
    if (dut != 1) begin e.dut = 0; q.push_back(e); end
    if (dut != 0) begin e.dut = 1; q.push_back(e); end
  endtask

  task automatic rd(input int a0, input int a1);
    rd_addr = {AW'(a1), AW'(a0)};
  endtask

  task automatic wr(input logic en, input int a, input logic [31:0] d);
    wr_en = en; wr_addr = AW'(a); wr_data = d;
  endtask

  task automatic iss(input logic en, input int a);
    iss_en = en; iss_addr = AW'(a);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.kind)
        0:       act = (e.dut != 0) ? rd_data_n[e.port*DW +: DW] : rd_data_b[e.port*DW +: DW];
        1:       act = {31'd0, (e.dut != 0) ? rd_busy_n[e.port] : rd_busy_b[e.port]};
        default: act = {26'd0, (e.dut != 0) ? pend_cnt_n : pend_cnt_b};
      endcase
      n_chk++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s (dut%0d port%0d): got 0x%0h expected 0x%0h",
                 e.name, e.dut, e.port, act, e.exp);
      end
    end
  end

  initial begin
    #100000;
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL watchdog: test did not complete before timeout");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
    end
  end

  initial begin
    reset = 1'b0; wr(1, 3, 32'hAA); iss(0, 0); rd(3, 3);
    #1;
    n_chk++;
    if (rd_data_b !== '0 || rd_data_n !== '0 || rd_busy_b !== '0 || rd_busy_n !== '0 ||
        pend_cnt_b !== '0 || pend_cnt_n !== '0) begin
      n_fail++;
      $display("FAIL rst_state: data 0x%0h/0x%0h busy %b/%b cnt %0d/%0d",
               rd_data_b, rd_data_n, rd_busy_b, rd_busy_n, pend_cnt_b, pend_cnt_n);
    end
    ex("rst_data", 0, 2, 0, 0); ex("rst_busy", 1, 2, 0, 0); ex("rst_cnt", 2, 2, 0, 0);
    tick();
    ex("rst_data2", 0, 2, 0, 0); ex("rst_cnt2", 2, 2, 0, 0);
    tick();
    reset = 1'b1; wr(0, 0, 0);
    ex("post_rst_r3", 0, 2, 0, 0);
    tick();

    wr(1, 1, 10); tick();
    wr(1, 2, 20); tick();
    wr(0, 0, 0); rd(1, 2);
    ex("rd_r1", 0, 2, 0, 10); ex("rd_r2", 0, 2, 1, 20);
    tick();
    wr(1, 1, 30);
    ex("ovw_byp", 0, 0, 0, 30); ex("ovw_nobyp_old", 0, 1, 0, 10);
    tick();
    wr(0, 0, 0);
    ex("ovw_r1", 0, 2, 0, 30);
    tick();

    wr(1, 14, 300); rd(14, 2);
    ex("byp_fwd", 0, 0, 0, 300); ex("nobyp_old", 0, 1, 0, 0);
    tick();
    wr(0, 0, 0);
    ex("byp_next", 0, 2, 0, 300);
    tick();

    wr(1, 0, 32'h1234); iss(1, 0); rd(0, 2);
    ex("r0_data", 0, 2, 0, 0); ex("r0_busy", 1, 2, 0, 0);
    tick();
    wr(0, 0, 0); iss(0, 0);
    ex("r0_data_after", 0, 2, 0, 0); ex("r0_busy_after", 1, 2, 0, 0); ex("r0_cnt", 2, 2, 0, 0);
    tick();

    iss(1, 5); rd(5, 6);
    ex("iss_not_visible", 1, 2, 0, 0);
    tick();
    iss(1, 6);
    ex("r5_busy", 1, 2, 0, 1); ex("cnt1", 2, 2, 0, 1);
    tick();
    iss(0, 0);
    ex("r5_busy2", 1, 2, 0, 1); ex("r6_busy", 1, 2, 1, 1); ex("cnt2", 2, 2, 0, 2);
    tick();
    wr(1, 5, 55);
    ex("wb_busy_byp", 1, 0, 0, 0); ex("wb_data_byp", 0, 0, 0, 55);
    ex("wb_busy_nobyp", 1, 1, 0, 1); ex("wb_data_nobyp", 0, 1, 0, 0);
    ex("wb_cnt_same_cycle", 2, 2, 0, 2);
    tick();
    wr(0, 0, 0);
    ex("wb_cnt", 2, 2, 0, 1); ex("r5_clear", 1, 2, 0, 0); ex("r6_still", 1, 2, 1, 1);
    ex("r5_data", 0, 2, 0, 55);
    tick();

    iss(1, 7); tick();
    iss(0, 0); rd(7, 6);
    ex("r7_pend", 1, 2, 0, 1); ex("cnt_r6r7", 2, 2, 0, 2);
    tick();
    wr(1, 7, 77); iss(1, 7);
    ex("sim_busy_byp", 1, 0, 0, 0); ex("sim_data_byp", 0, 0, 0, 77);
    tick();
    wr(0, 0, 0); iss(0, 0);
    ex("sim_cnt", 2, 2, 0, 2); ex("sim_r7_busy", 1, 2, 0, 1); ex("sim_r7_data", 0, 2, 0, 77);
    tick();

    wr(1, 6, 66); iss(1, 8); tick();
    wr(0, 0, 0); iss(0, 0); rd(6, 8);
    ex("diff_cnt", 2, 2, 0, 2); ex("diff_r6_busy", 1, 2, 0, 0); ex("diff_r8_busy", 1, 2, 1, 1);
    ex("diff_r6_data", 0, 2, 0, 66);
    tick();

    rd(7, 8); reset = 1'b0;
    ex("mid_rst_cnt", 2, 2, 0, 0); ex("mid_rst_busy", 1, 2, 1, 0); ex("mid_rst_data", 0, 2, 0, 0);
    tick();
    reset = 1'b1;
    ex("after_rst_r7", 0, 2, 0, 0); ex("after_rst_busy", 1, 2, 0, 0); ex("after_rst_cnt", 2, 2, 0, 0);
    tick();
    wr(1, 9, 99); iss(1, 10); rd(9, 10); tick();
    wr(0, 0, 0); iss(0, 0);
    ex("rel_r9", 0, 2, 0, 99); ex("rel_r10_busy", 1, 2, 1, 1); ex("rel_cnt", 2, 2, 0, 1);
    tick();
    tick();

    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations never checked", q.size());
    end

    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-read-port register file for the CPU datapath. Generalises the fixed 32x32, two-read/one-write register file to a configurable width, depth and read-port count. Adds write-to-read bypass, an optional hardwired zero register, and a per-register pending scoreboard. The decode stage uses the scoreboard to detect read-after-write hazards against in-flight instructions. Sits between the decode/issue stage and the writeback stage.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes, never goes pending
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
rd_addr  in  NUM_RD*ADDR_W  read addresses; port i = bits [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  read data, port i packed the same way
rd_busy  out  NUM_RD  1 = register addressed by port i is pending
wr_en  in  1  writeback enable
wr_addr  in  ADDR_W  writeback address
wr_data  in  DATA_W  writeback data
iss_en  in  1  issue: mark iss_addr pending
iss_addr  in  ADDR_W  destination register of the issuing instruction
pend_cnt  out  ADDR_W+1  number of registers currently pending

Behaviour:
- Reset (reset=0, asynchronous): all registers = 0, all pending bits = 0, pend_cnt = 0. While reset=0, rd_data = 0 and rd_busy = 0 on every port; bypass is gated off.
- Write: on a clk edge with wr_en=1, reg[wr_addr] <= wr_data and pending[wr_addr] <= 0. If ZERO_REG=1 and wr_addr=0, the write is dropped.
- Issue: on a clk edge with iss_en=1, pending[iss_addr] <= 1. If ZERO_REG=1 and iss_addr=0, the issue is dropped.
- Same-address wr_en and iss_en in one cycle: the register is written, and pending ends at 1 (issue wins: a new producer is in flight).
- Different addresses in one cycle: both take effect independently.
- Issuing to an already-pending register: pending stays 1 and pend_cnt is unchanged.
- Writing to a non-pending register: data is written and pend_cnt is unchanged.
- Read path is combinational, zero-cycle latency. For each port i:
  - rd_data[i] = reg[rd_addr[i]], or 0 if ZERO_REG=1 and rd_addr[i]=0.
  - If BYPASS=1, wr_en=1 and wr_addr=rd_addr[i] (not the dropped zero case): rd_data[i] = wr_data.
  - rd_busy[i] = pending[rd_addr[i]], forced to 0 when the bypass condition above is true.
- rd_busy ignores an iss_en in the same cycle. The issue becomes visible on the next cycle.
- With BYPASS=0, read-after-write in the same cycle returns old data and old busy. The new value appears the following cycle.
- pend_cnt is registered and equals the popcount of the pending bits after every edge. It is updated incrementally (+1 set, -1 clear, 0 for both or neither), never recomputed by an adder tree.
- Reset deasserted mid-stream: the first edge after deassertion behaves as normal. There is no extra wait state.

Decomposition:
- Shared package regfile_pkg: default DATA_W/ADDR_W constants and the port-slice helper functions used to index the packed rd_addr/rd_data buses.
- One sub-module, regfile_scoreboard: pending bit vector, pend_cnt and the issue/writeback priority logic.
- The data array and the read/bypass multiplexers stay in regfile_mp.

Test Plan:
- Reset: hold reset=0 for 2 cycles with wr_en=1, wr_addr=3, wr_data=0xAA -> rd_data=0, rd_busy=0, pend_cnt=0. After release, reg3 reads 0.
- Write/read: write 10 to r1 and 20 to r2 in consecutive cycles, then read addr1=1, addr2=2 -> 10 and 20. Overwrite r1 with 30 -> port0 reads 30.
- Bypass: wr_en=1, wr_addr=14, wr_data=300, rd_addr[0]=14 in the same cycle -> rd_data[0]=300 combinationally, with no wait for the edge. With BYPASS=0 -> old value, then 300 next cycle.
- Zero register: write 0x1234 to r0 and issue r0 -> r0 reads 0, rd_busy=0, pend_cnt unchanged.
- Scoreboard: issue r5, then r6 -> pend_cnt=2 and rd_busy set for ports reading 5/6. Write r5 -> pend_cnt=1. In the write cycle a port reading r5 sees busy=0 and the forwarded data.
- Simultaneous: pending r7, then wr_en and iss_en both on r7 in one cycle -> data written, r7 still pending, pend_cnt unchanged. Assert reset mid-sequence -> all pending cleared immediately.
